ahb3lite_dma_write_master: RTL and testbench

- AHB-Lite write-direction DMA master; the counterpart of the read DMA/FIFO-serializer path.
- Accepts a byte stream, packs little-endian bytes into 32-bit words, and buffers them in a 4-word FIFO.
- Writes i_RCC_BUFFER_LENGTH words to memory starting at {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW} using pipelined SINGLE transfers.
- Sits between the inbound byte source and the memory-side AHB-Lite slave.

---
 rtl/ahb3lite_dma_write_master.sv | 213 +++++++++++++++++++++
 tb/tb_ahb3lite_dma_write_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_dma_write_master.sv
// AHB-Lite write-direction DMA master.
// Packs an inbound byte stream into little-endian 32-bit words, buffers them in a small FIFO
// and writes them to consecutive word addresses using pipelined SINGLE transfers.
module ahb3lite_dma_write_master #(
    parameter int unsigned BUF_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        i_CoreSystemStart,
    input  logic [5:0]  i_RCC_BUFFER_LENGTH,
    input  logic [15:0] i_RCC_DMA_ADDR_HIGH,
    input  logic [15:0] i_RCC_DMA_ADDR_LOW,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HBURST,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error
);

    localparam int unsigned PtrW = $clog2(BUF_DEPTH);
    localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StErr, StDone} state_e;

    state_e            state_q, state_d;
    logic [31:0]       base_q;
    logic [5:0]        len_q;
    logic [6:0]        issued_q;
    logic [7:0]        acc_q;
    logic [1:0]        pack_cnt_q;
    logic [23:0]       pack_buf_q;
    logic [31:0]       mem_q [BUF_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, iss_ptr_q;
    logic [CntW-1:0]   count_q;
    // Buffered words whose address phase has not been accepted yet
    logic [CntW-1:0]   unissued_q;
    logic [CntW-1:0]   unissued_avail;
    logic              dp_valid_q;
    logic [31:0]       haddr_q, hwdata_q;
    logic              hwrite_q;
    logic [1:0]        htrans_q;
    logic              error_q;

    logic byte_fire, push, addr_accept, data_ok, err_first, err_second, issue;

    assign err_first   = dp_valid_q && HRESP && !HREADY;
    assign err_second  = dp_valid_q && HRESP && HREADY;
    assign data_ok     = dp_valid_q && HREADY && !HRESP;
    assign addr_accept = HREADY && (htrans_q == TransNonseq) && !err_second;

    assign o_byte_ready = (state_q == StRun) && (acc_q < {len_q, 2'b00})
                          && (count_q != CntW'(BUF_DEPTH));
    assign byte_fire    = i_byte_valid && o_byte_ready;
    assign push         = byte_fire && (pack_cnt_q == 2'd3);

    // A word already committed to the accepted address phase cannot be issued again
    assign unissued_avail = unissued_q - CntW'(addr_accept);
    assign issue = (state_q == StRun) && HREADY && !err_second
                   && (issued_q < {1'b0, len_q}) && (unissued_avail != '0);

    assign HADDR  = haddr_q;
    assign HWRITE = hwrite_q;
    assign HTRANS = htrans_q;
    assign HWDATA = hwdata_q;
    assign HBURST = 3'b000;
    assign HSIZE  = 3'b010;
    assign o_busy  = (state_q == StRun) || (state_q == StDrain) || (state_q == StErr);
    assign o_done  = (state_q == StDone);
    assign o_error = error_q;

    // Control state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (i_CoreSystemStart) begin
                    state_d = (i_RCC_BUFFER_LENGTH == 6'd0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (err_second) begin
                    state_d = StErr;
                end else if (issued_q == {1'b0, len_q}) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (err_second) begin
                    state_d = StErr;
                end else if (data_ok && (htrans_q == TransIdle)) begin
                    state_d = StDone;
                end
            end
            StErr:   state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Word buffer storage; contents only matter once written
    always_ff @(posedge HCLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {i_byte, pack_buf_q};
        end
    end

    // Transfer bookkeeping, byte packing, buffer pointers and the AHB address/data pipeline
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            acc_q      <= '0;
            pack_cnt_q <= '0;
            pack_buf_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            iss_ptr_q  <= '0;
            count_q    <= '0;
            unissued_q <= '0;
            dp_valid_q <= 1'b0;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            hwrite_q   <= 1'b0;
            htrans_q   <= TransIdle;
            error_q    <= 1'b0;
        end else begin
            if ((state_q == StIdle) && i_CoreSystemStart) begin
                base_q   <= {i_RCC_DMA_ADDR_HIGH, i_RCC_DMA_ADDR_LOW};
                len_q    <= i_RCC_BUFFER_LENGTH;
                issued_q <= '0;
                acc_q    <= '0;
                error_q  <= 1'b0;
            end

            if (byte_fire) begin
                acc_q      <= acc_q + 8'd1;
                pack_cnt_q <= pack_cnt_q + 2'd1;
                unique case (pack_cnt_q)
                    2'd0:    pack_buf_q[7:0]   <= i_byte;
                    2'd1:    pack_buf_q[15:8]  <= i_byte;
                    2'd2:    pack_buf_q[23:16] <= i_byte;
                    default: ;
                endcase
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (data_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (addr_accept) begin
                iss_ptr_q <= iss_ptr_q + PtrW'(1);
            end
            count_q    <= count_q + CntW'(push) - CntW'(data_ok);
            unissued_q <= unissued_q + CntW'(push) - CntW'(addr_accept);

            if (HREADY) begin
                dp_valid_q <= addr_accept;
                if (addr_accept) begin
                    hwdata_q <= mem_q[iss_ptr_q];
                end
                if (issue) begin
                    htrans_q <= TransNonseq;
                    hwrite_q <= 1'b1;
                    haddr_q  <= base_q + 32'({issued_q, 2'b00});
                    issued_q <= issued_q + 7'd1;
                end else begin
                    htrans_q <= TransIdle;
                    hwrite_q <= 1'b0;
                end
            end else if (err_first) begin
                // Cancel any pipelined address while the slave signals ERROR
                htrans_q <= TransIdle;
                hwrite_q <= 1'b0;
            end

            if (err_second) begin
                dp_valid_q <= 1'b0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                iss_ptr_q  <= '0;
                count_q    <= '0;
                unissued_q <= '0;
                pack_cnt_q <= '0;
                error_q    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb3lite_dma_write_master.sv
// Self-checking bench for ahb3lite_dma_write_master: a byte source and an AHB-Lite slave model
// run on the falling edge; expected writes are queued when a transfer is set up and compared
// when the slave sees each data phase complete.
module tb_ahb3lite_dma_write_master;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        i_CoreSystemStart = 1'b0;
    logic [5:0]  i_RCC_BUFFER_LENGTH = '0;
    logic [15:0] i_RCC_DMA_ADDR_HIGH = '0;
    logic [15:0] i_RCC_DMA_ADDR_LOW = '0;
    logic [7:0]  i_byte = '0;
    logic        i_byte_valid = 1'b0;
    logic        o_byte_ready;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HBURST;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY = 1'b1;
    logic        HRESP = 1'b0;
    logic        o_busy;
    logic        o_done;
    logic        o_error;

    ahb3lite_dma_write_master #(.BUF_DEPTH(4)) dut (
        .HCLK                (HCLK),
        .HRESETn             (HRESETn),
        .i_CoreSystemStart   (i_CoreSystemStart),
        .i_RCC_BUFFER_LENGTH (i_RCC_BUFFER_LENGTH),
        .i_RCC_DMA_ADDR_HIGH (i_RCC_DMA_ADDR_HIGH),
        .i_RCC_DMA_ADDR_LOW  (i_RCC_DMA_ADDR_LOW),
        .i_byte              (i_byte),
        .i_byte_valid        (i_byte_valid),
        .o_byte_ready        (o_byte_ready),
        .HADDR               (HADDR),
        .HWRITE              (HWRITE),
        .HTRANS              (HTRANS),
        .HBURST              (HBURST),
        .HSIZE               (HSIZE),
        .HWDATA              (HWDATA),
        .HREADY              (HREADY),
        .HRESP               (HRESP),
        .o_busy              (o_busy),
        .o_done              (o_done),
        .o_error             (o_error)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Scoreboard entries are {address, data}
    logic [63:0] sb_q[$];
    logic [7:0]  feed_q[$];
    bit          feed_en = 1'b0;
    int          acc_bytes = 0;
    bit          rdy_prev = 1'b0;
    bit          ready_low_seen = 1'b0;
    bit          ready_high_seen = 1'b0;

    bit          dp_active = 1'b0;
    logic [31:0] dp_addr = '0;
    int          dp_idx = 0;
    int          issued_cnt = 0;
    int          completed = 0;
    int          last_dp_cyc = 0;
    int          acc_at_first_pop = -1;
    int          wait_idx = -1;
    int          wait_n = 0;
    int          wait_left = 0;
    int          err_idx = -1;
    int          err_phase = 0;
    bit          err_done = 1'b0;
    int          post_err_nonseq = 0;
    bit          stalled = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;

    bit          done_seen = 1'b0;
    int          done_cyc = 0;
    int          done_c = 0;

    // Byte source and AHB slave model
    always @(negedge HCLK) begin
        logic        hr;
        logic        hs;
        logic [63:0] e;
        if (!HRESETn) begin
            dp_active    = 1'b0;
            rdy_prev     = 1'b0;
            i_byte_valid = 1'b0;
            HREADY       = 1'b1;
            HRESP        = 1'b0;
            stalled      = 1'b0;
        end else begin
            if (i_byte_valid && rdy_prev && feed_q.size() > 0) begin
                acc_bytes++;
                void'(feed_q.pop_front());
            end
            if (feed_en && feed_q.size() > 0) begin
                i_byte_valid = 1'b1;
                i_byte       = feed_q[0];
            end else begin
                i_byte_valid = 1'b0;
            end
            rdy_prev = o_byte_ready;
            if (o_byte_ready) ready_high_seen = 1'b1;
            if (feed_en && feed_q.size() > 0 && o_busy && !o_byte_ready) ready_low_seen = 1'b1;

            hr = 1'b1;
            hs = 1'b0;
            if (dp_active) begin
                if (err_phase == 1) begin
                    hs = 1'b1;
                    err_phase = 2;
                    check_eq("htrans_cancel", 32'(HTRANS), 32'd0);
                end else if (dp_idx == err_idx && err_phase == 0) begin
                    hr = 1'b0;
                    hs = 1'b1;
                    err_phase = 1;
                end else if (dp_idx == wait_idx && wait_left > 0) begin
                    hr = 1'b0;
                    wait_left--;
                    if (!stalled) begin
                        stalled = 1'b1;
                        st_addr = HADDR;
                        st_data = HWDATA;
                    end else begin
                        check_eq("stall_haddr", HADDR, st_addr);
                        check_eq("stall_hwdata", HWDATA, st_data);
                    end
                end
            end
            if (hr && stalled) begin
                check_eq("stall_haddr", HADDR, st_addr);
                check_eq("stall_hwdata", HWDATA, st_data);
                stalled = 1'b0;
            end
            HREADY = hr;
            HRESP  = hs;

            if (hr) begin
                if (dp_active && !hs) begin
                    check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check_eq("wr_addr", dp_addr, e[63:32]);
                        check_eq("wr_data", HWDATA, e[31:0]);
                    end
                    if (completed == 0) acc_at_first_pop = acc_bytes;
                    completed++;
                    last_dp_cyc = cyc;
                end
                if (dp_active && hs) begin
                    err_done = 1'b1;
                end else if (err_done && HTRANS == 2'b10) begin
                    post_err_nonseq++;
                end
                dp_active = (HTRANS == 2'b10);
                if (dp_active) begin
                    dp_addr = HADDR;
                    dp_idx  = issued_cnt;
                    issued_cnt++;
                    check_eq("hwrite", 32'(HWRITE), 32'd1);
                end
            end
        end
    end

    // Queue bytes and expected writes, pulse start, and wait (bounded) for o_done
    task automatic run_xfer(input logic [31:0] base, input int len,
                            input logic [7:0] b0, input logic [7:0] step);
        sb_q.delete();
        feed_q.delete();
        acc_bytes        = 0;
        completed        = 0;
        issued_cnt       = 0;
        err_phase        = 0;
        err_done         = 1'b0;
        post_err_nonseq  = 0;
        ready_low_seen   = 1'b0;
        ready_high_seen  = 1'b0;
        acc_at_first_pop = -1;
        wait_left        = wait_n;
        stalled          = 1'b0;
        for (int w = 0; w < len; w++) begin
            logic [31:0] word;
            logic [7:0]  b;
            for (int k = 0; k < 4; k++) begin
                b = 8'(int'(b0) + int'(step) * (4 * w + k));
                feed_q.push_back(b);
                word[8*k +: 8] = b;
            end
            sb_q.push_back({base + 32'(4 * w), word});
        end
        @(negedge HCLK);
        i_RCC_DMA_ADDR_HIGH = base[31:16];
        i_RCC_DMA_ADDR_LOW  = base[15:0];
        i_RCC_BUFFER_LENGTH = 6'(len);
        i_CoreSystemStart   = 1'b1;
        feed_en             = 1'b1;
        done_seen           = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge HCLK);
            i_CoreSystemStart = 1'b0;
            if (o_done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                done_c    = c;
                break;
            end
        end
        check_eq("done_seen", 32'(done_seen), 32'd1);
        check_eq("busy_at_done", 32'(o_busy), 32'd0);
        feed_en = 1'b0;
        @(negedge HCLK);
        check_eq("done_one_cycle", 32'(o_done), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge HCLK);
        #1;
        check_eq("rst_htrans", 32'(HTRANS), 32'd0);
        check_eq("rst_hwrite", 32'(HWRITE), 32'd0);
        check_eq("rst_haddr", HADDR, 32'd0);
        check_eq("rst_hwdata", HWDATA, 32'd0);
        check_eq("rst_ready", 32'(o_byte_ready), 32'd0);
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_done", 32'(o_done), 32'd0);
        check_eq("rst_error", 32'(o_error), 32'd0);
        check_eq("hburst", 32'(HBURST), 32'd0);
        check_eq("hsize", 32'(HSIZE), 32'd2);
        HRESETn = 1'b1;

        // Basic two-word write
        wait_idx = -1; err_idx = -1;
        run_xfer(32'h1000_0000, 2, 8'h01, 8'h01);
        check_eq("t1_words", 32'(completed), 32'd2);
        check_eq("t1_sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("t1_bytes", 32'(acc_bytes), 32'd8);
        check_eq("t1_done_lat", 32'(done_cyc - last_dp_cyc), 32'd1);

        // Address wraps past 2^32
        run_xfer(32'hFFFF_FFFC, 2, 8'h10, 8'h03);
        check_eq("t2_words", 32'(completed), 32'd2);
        check_eq("t2_sb_empty", 32'(sb_q.size()), 32'd0);

        // Three wait states on the second data phase
        wait_idx = 1; wait_n = 3;
        run_xfer(32'h2000_0100, 8, 8'h30, 8'h07);
        check_eq("t3_words", 32'(completed), 32'd8);
        check_eq("t3_sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("t3_bytes", 32'(acc_bytes), 32'd32);

        // Long stall on the first data phase fills the buffer
        wait_idx = 0; wait_n = 20;
        run_xfer(32'h2000_0200, 8, 8'h5A, 8'h0D);
        check_eq("t4_ready_low", 32'(ready_low_seen), 32'd1);
        check_eq("t4_fill_bytes", 32'(acc_at_first_pop), 32'd16);
        check_eq("t4_words", 32'(completed), 32'd8);
        check_eq("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // ERROR response on the third of five words
        wait_idx = -1; wait_n = 0; err_idx = 2;
        run_xfer(32'h3000_0000, 5, 8'h80, 8'h01);
        check_eq("t5_error", 32'(o_error), 32'd1);
        check_eq("t5_words", 32'(completed), 32'd2);
        check_eq("t5_sb_left", 32'(sb_q.size()), 32'd3);
        repeat (4) @(negedge HCLK);
        check_eq("t5_no_nonseq", 32'(post_err_nonseq), 32'd0);
        check_eq("t5_error_sticky", 32'(o_error), 32'd1);
        err_idx = -1;

        // Zero-length start clears the error and completes without bus traffic
        run_xfer(32'h4000_0000, 0, 8'h00, 8'h01);
        check_eq("t6_error_clr", 32'(o_error), 32'd0);
        check_eq("t6_latency", 32'(done_c), 32'd0);
        check_eq("t6_no_xfer", 32'(issued_cnt), 32'd0);
        check_eq("t6_no_ready", 32'(ready_high_seen), 32'd0);

        // Reset in the middle of a word, then restart
        sb_q.delete();
        feed_q.delete();
        for (int k = 0; k < 8; k++) feed_q.push_back(8'(8'h11 * (k + 1)));
        acc_bytes = 0;
        @(negedge HCLK);
        i_RCC_DMA_ADDR_HIGH = 16'h5000;
        i_RCC_DMA_ADDR_LOW  = 16'h0000;
        i_RCC_BUFFER_LENGTH = 6'd2;
        i_CoreSystemStart   = 1'b1;
        feed_en             = 1'b1;
        @(negedge HCLK);
        i_CoreSystemStart = 1'b0;
        for (int c = 0; c < 50 && acc_bytes < 2; c++) @(negedge HCLK);
        check_eq("t7_busy_before", 32'(o_busy), 32'd1);
        HRESETn = 1'b0;
        feed_en = 1'b0;
        feed_q.delete();
        #1;
        check_eq("t7_rst_htrans", 32'(HTRANS), 32'd0);
        check_eq("t7_rst_busy", 32'(o_busy), 32'd0);
        check_eq("t7_rst_ready", 32'(o_byte_ready), 32'd0);
        check_eq("t7_rst_haddr", HADDR, 32'd0);
        check_eq("t7_rst_hwdata", HWDATA, 32'd0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        run_xfer(32'h4000_0010, 1, 8'hAA, 8'h11);
        check_eq("t7_words", 32'(completed), 32'd1);
        check_eq("t7_sb_empty", 32'(sb_q.size()), 32'd0);
        check_eq("t7_bytes", 32'(acc_bytes), 32'd4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
